// File: rtl/gray_pkg.sv
// gray_pkg
//   Shared helpers for the Gray-coded counter/comparator family.
//   - CMP_GT / CMP_EQ / CMP_LT : one-hot comparison result encodings,
//     ordered to match the {greater, equal, less} flag bundle.
//   - max_count(w)  : terminal count (2^w - 1) for a w-bit counter (w <= 32).
//   - bin2gray(b)   : binary -> reflected Gray (zero-extended to 32 bits).
//   - gray2bin(g)   : reflected Gray -> binary (zero-extended to 32 bits).
//   The conversions work on 32-bit containers; narrower values are simply
//   zero-extended, which leaves both conversions correct for any width <= 32.
package gray_pkg;

  localparam int MAX_WIDTH = 32;

  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

  function automatic logic [MAX_WIDTH-1:0] max_count(input int w);
    logic [MAX_WIDTH:0] one_ext;
    one_ext = {{MAX_WIDTH{1'b0}}, 1'b1};
    // Computed one bit wider so w == 32 does not overflow the shift.
    max_count = MAX_WIDTH'((one_ext << w) - 1'b1);
  endfunction

  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
    bin2gray = b ^ (b >> 1);
  endfunction

  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    // Each binary bit is the XOR of all Gray bits at or above it.
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = g[i] ^ b[i+1];
    end
    gray2bin = b;
  endfunction

endpackage

// File: rtl/gray_encoder.sv
// gray_encoder
//   Purely combinational binary -> reflected Gray converter.
//   Ports:
//     bin_in   [WIDTH-1:0]  binary value
//     gray_out [WIDTH-1:0]  Gray code of bin_in (MSB passes straight through)
module gray_encoder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin_in,
  output logic [WIDTH-1:0] gray_out
);

  assign gray_out[WIDTH-1] = bin_in[WIDTH-1];

  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_bit
      assign gray_out[gi] = bin_in[gi] ^ bin_in[gi+1];
    end
  endgenerate

endmodule

// File: rtl/gray_counter_cmp.sv
// gray_counter_cmp
//   Up/down counter with registered binary and Gray outputs and a registered
//   unsigned comparison against a programmable threshold. Intended as the
//   pointer/threshold element of clock-crossing FIFOs and event timers: the
//   Gray output goes to the far domain, the compare flags to local control.
//   Every output is registered from the same next-count value, so binary,
//   Gray and flags always describe the same count.
//   Ports:
//     clk              rising-edge clock
//     reset            synchronous active-high reset, dominates all inputs
//     enable_in        step the counter this edge
//     up_down_in       1 = increment, 0 = decrement
//     load_in          load load_value_in (beats enable_in)
//     load_value_in    binary load value
//     compare_in       binary threshold, takes effect at the next edge
//     binary_out       registered binary count
//     gray_out         registered Gray code of binary_out
//     count_greater    binary_out >  compare_in
//     count_equal      binary_out == compare_in
//     count_less       binary_out <  compare_in
//     match_pulse_out  one-cycle pulse when count_equal rises
//     wrap_out         one-cycle pulse on terminal-count wrap (WRAP_EN=1)
//   Parameters:
//     WIDTH    counter/threshold width, >= 2
//     WRAP_EN  1: wrap at the terminal counts, 0: saturate at 0 and max
module gray_counter_cmp
  import gray_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter bit WRAP_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_in,
  input  logic             up_down_in,
  input  logic             load_in,
  input  logic [WIDTH-1:0] load_value_in,
  input  logic [WIDTH-1:0] compare_in,
  output logic [WIDTH-1:0] binary_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             count_greater,
  output logic             count_equal,
  output logic             count_less,
  output logic             match_pulse_out,
  output logic             wrap_out
);

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(max_count(WIDTH));

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] gray_q,  gray_d;
  logic [2:0]       cmp_q,   cmp_d;
  logic             match_q, match_d;
  logic             wrap_q,  wrap_d;

  // Next-count and wrap detection. Load wins over stepping and never wraps.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load_in) begin
      count_d = load_value_in;
    end else if (enable_in) begin
      if (up_down_in) begin
        if (count_q == MAX_COUNT) begin
          if (WRAP_EN) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          if (WRAP_EN) begin
            count_d = MAX_COUNT;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  // Compare the value that is about to be registered, so the flags carry the
  // same one-cycle latency as binary_out rather than lagging it by a cycle.
  always_comb begin
    cmp_d = CMP_LT;
    if (count_d > compare_in) begin
      cmp_d = CMP_GT;
    end else if (count_d == compare_in) begin
      cmp_d = CMP_EQ;
    end
    // Rising edge of "equal": a hold on the threshold pulses once only.
    match_d = (cmp_d == CMP_EQ) && (cmp_q != CMP_EQ);
  end

  gray_encoder #(
    .WIDTH (WIDTH)
  ) u_gray_encoder (
    .bin_in   (count_d),
    .gray_out (gray_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      gray_q  <= '0;
      cmp_q   <= '0;
      match_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      gray_q  <= gray_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
      wrap_q  <= wrap_d;
    end
  end

  assign binary_out      = count_q;
  assign gray_out        = gray_q;
  assign count_greater   = cmp_q[2];
  assign count_equal     = cmp_q[1];
  assign count_less      = cmp_q[0];
  assign match_pulse_out = match_q;
  assign wrap_out        = wrap_q;

endmodule

// File: tb/tb_gray_counter_cmp.sv
module tb_gray_counter_cmp;
  import gray_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the two 4-bit instances (wrapping and saturating).
  logic       reset = 1'b1;
  logic       enable_in = 1'b0;
  logic       up_down_in = 1'b1;
  logic       load_in = 1'b0;
  logic [3:0] load_value_in = '0;
  logic [3:0] compare_in = '0;

  logic [3:0] a_bin, a_gray, s_bin, s_gray;
  logic       a_gt, a_eq, a_lt, a_match, a_wrap;
  logic       s_gt, s_eq, s_lt, s_match, s_wrap;

  // 6-bit wrapping instance for the free-run test.
  logic       enable6 = 1'b0;
  logic       load6 = 1'b0;
  logic [5:0] load_value6 = '0;
  logic [5:0] compare6 = 6'd20;
  logic [5:0] w_bin, w_gray;
  logic       w_gt, w_eq, w_lt, w_match, w_wrap;

  int n_pass  = 0;
  int n_total = 0;

  gray_counter_cmp #(.WIDTH(4), .WRAP_EN(1'b1)) dut_a (
    .clk(clk), .reset(reset), .enable_in(enable_in), .up_down_in(up_down_in),
    .load_in(load_in), .load_value_in(load_value_in), .compare_in(compare_in),
    .binary_out(a_bin), .gray_out(a_gray), .count_greater(a_gt),
    .count_equal(a_eq), .count_less(a_lt), .match_pulse_out(a_match),
    .wrap_out(a_wrap)
  );

  gray_counter_cmp #(.WIDTH(4), .WRAP_EN(1'b0)) dut_s (
    .clk(clk), .reset(reset), .enable_in(enable_in), .up_down_in(up_down_in),
    .load_in(load_in), .load_value_in(load_value_in), .compare_in(compare_in),
    .binary_out(s_bin), .gray_out(s_gray), .count_greater(s_gt),
    .count_equal(s_eq), .count_less(s_lt), .match_pulse_out(s_match),
    .wrap_out(s_wrap)
  );

  gray_counter_cmp #(.WIDTH(6), .WRAP_EN(1'b1)) dut_w (
    .clk(clk), .reset(reset), .enable_in(enable6), .up_down_in(1'b1),
    .load_in(load6), .load_value_in(load_value6), .compare_in(compare6),
    .binary_out(w_bin), .gray_out(w_gray), .count_greater(w_gt),
    .count_equal(w_eq), .count_less(w_lt), .match_pulse_out(w_match),
    .wrap_out(w_wrap)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one edge, then sample 1 ns later, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] a_all, s_all;
  logic [5:0]  prev_gray;
  logic [5:0]  k6;

  always_comb begin
    a_all = {19'd0, a_bin, a_gray, a_gt, a_eq, a_lt, a_match, a_wrap};
    s_all = {19'd0, s_bin, s_gray, s_gt, s_eq, s_lt, s_match, s_wrap};
  end

  initial begin
    // Power-on reset, two edges.
    tick(); tick();
    chk("reset_a_all", a_all, 32'd0);
    chk("reset_w_bin", {26'd0, w_bin}, 32'd0);

    // Test 1: bring count to 9, reset for two cycles while counting.
    reset = 1'b0; load_in = 1'b1; load_value_in = 4'd9; compare_in = 4'd3;
    tick();
    chk("t1_load9_bin", a_bin, 32'd9);
    chk("t1_load9_gray", a_gray, 32'hD);
    chk("t1_load9_gt", a_gt, 32'd1);
    reset = 1'b1; load_in = 1'b0; enable_in = 1'b1; up_down_in = 1'b1;
    tick();
    chk("t1_rst1_a_all", a_all, 32'd0);
    chk("t1_rst1_s_all", s_all, 32'd0);
    tick();
    chk("t1_rst2_a_all", a_all, 32'd0);
    reset = 1'b0; enable_in = 1'b0;
    tick();
    chk("t1_idle_bin", a_bin, 32'd0);
    chk("t1_idle_lt", a_lt, 32'd1);
    chk("t1_idle_eq", a_eq, 32'd0);
    chk("t1_idle_gt", a_gt, 32'd0);

    // Test 2: load onto threshold, one match pulse, then hold.
    load_in = 1'b1; load_value_in = 4'd5; compare_in = 4'd5;
    tick();
    chk("t2_bin", a_bin, 32'd5);
    chk("t2_gray", a_gray, 32'h7);
    chk("t2_eq", a_eq, 32'd1);
    chk("t2_lt", a_lt, 32'd0);
    chk("t2_match", a_match, 32'd1);
    load_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_hold_match", a_match, 32'd0);
      chk("t2_hold_eq", a_eq, 32'd1);
    end
    // A threshold change that creates equality also pulses.
    compare_in = 4'd6;
    tick();
    chk("t2_cmp6_lt", a_lt, 32'd1);
    chk("t2_cmp6_match", a_match, 32'd0);
    compare_in = 4'd5;
    tick();
    chk("t2_cmp5_match", a_match, 32'd1);

    // Tests 3/4: wrap vs saturate from 14 upward.
    load_in = 1'b1; load_value_in = 4'd14;
    tick();
    chk("t3_load14_a", a_bin, 32'd14);
    chk("t4_load14_s", s_bin, 32'd14);
    load_in = 1'b0; enable_in = 1'b1; up_down_in = 1'b1;
    tick();
    chk("t3_up1_bin", a_bin, 32'd15);
    chk("t3_up1_gray", a_gray, 32'h8);
    chk("t3_up1_wrap", a_wrap, 32'd0);
    chk("t4_up1_bin", s_bin, 32'd15);
    tick();
    chk("t3_up2_bin", a_bin, 32'd0);
    chk("t3_up2_gray", a_gray, 32'd0);
    chk("t3_up2_wrap", a_wrap, 32'd1);
    chk("t4_up2_bin", s_bin, 32'd15);
    chk("t4_up2_wrap", s_wrap, 32'd0);
    tick();
    chk("t3_up3_bin", a_bin, 32'd1);
    chk("t3_up3_wrap", a_wrap, 32'd0);
    chk("t4_up3_bin", s_bin, 32'd15);
    chk("t4_up3_gray", s_gray, 32'h8);

    // Down from 0: a load of 0 first (loads never wrap).
    load_in = 1'b1; load_value_in = 4'd0;
    tick();
    chk("t3_load0_bin", a_bin, 32'd0);
    chk("t3_load0_wrap", a_wrap, 32'd0);
    chk("t4_load0_bin", s_bin, 32'd0);
    load_in = 1'b0; up_down_in = 1'b0;
    tick();
    chk("t3_dn1_bin", a_bin, 32'd15);
    chk("t3_dn1_gray", a_gray, 32'h8);
    chk("t3_dn1_wrap", a_wrap, 32'd1);
    chk("t4_dn1_bin", s_bin, 32'd0);
    chk("t4_dn1_wrap", s_wrap, 32'd0);
    tick();
    chk("t3_dn2_bin", a_bin, 32'd14);
    chk("t3_dn2_wrap", a_wrap, 32'd0);
    chk("t4_dn2_bin", s_bin, 32'd0);

    // Test 5: load beats enable.
    load_in = 1'b1; enable_in = 1'b1; up_down_in = 1'b1; load_value_in = 4'd10;
    tick();
    chk("t5_bin", a_bin, 32'd10);
    chk("t5_gray", a_gray, 32'hF);
    chk("t5_wrap", a_wrap, 32'd0);
    chk("t5_s_bin", s_bin, 32'd10);
    load_in = 1'b0; enable_in = 1'b0;

    // Test 6: 6-bit free-run up, 40 edges, threshold 20.
    prev_gray = w_gray;
    chk("t6_start_bin", {26'd0, w_bin}, 32'd0);
    enable6 = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      k6 = 6'(k);
      chk("t6_bin", {26'd0, w_bin}, {26'd0, k6});
      chk("t6_gray", {26'd0, w_gray}, {26'd0, k6 ^ (k6 >> 1)});
      chk("t6_roundtrip", gray2bin({26'd0, w_gray}), {26'd0, w_bin});
      chk("t6_onebit", $countones(w_gray ^ prev_gray), 32'd1);
      chk("t6_gt", w_gt, (k > 20) ? 32'd1 : 32'd0);
      chk("t6_eq", w_eq, (k == 20) ? 32'd1 : 32'd0);
      chk("t6_lt", w_lt, (k < 20) ? 32'd1 : 32'd0);
      chk("t6_match", w_match, (k == 20) ? 32'd1 : 32'd0);
      prev_gray = w_gray;
    end
    enable6 = 1'b0;

    // Final reset clears everything on the next edge.
    reset = 1'b1;
    tick();
    chk("end_reset_w_bin", {26'd0, w_bin}, 32'd0);
    chk("end_reset_a_all", a_all, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
